div_arbiter: RTL and testbench

- Shares one sequential signed/unsigned divider between NUM_REQ requesters (trajectory math, scaling, pixel-mapping units).
- Round-robin arbitration; latches the winner's operands and pulses the divider start.
- Waits for the divider's ready pulse, then returns quotient/remainder to the winner with a one-cycle valid pulse.

---
 rtl/div_arbiter.sv | 166 ++++++++++++++++
 tb/tb_div_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin arbiter sharing one sequential divider between
//               NUM_REQ requesters. Optional DIV_ZERO_BYPASS_EN answers
//               zero-divisor requests locally without starting the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int WIDTH   = 13,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_sign,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]           resp_quotient,
    output logic [WIDTH-1:0]           resp_remainder,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       div_start,
    output logic                       div_sign,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    input  logic                       div_ready
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [WIDTH-1:0]   r_resp_q;
    logic [WIDTH-1:0]   r_resp_r;
    logic               r_div_start;
    logic               r_div_sign;
    logic [WIDTH-1:0]   r_div_dd;
    logic [WIDTH-1:0]   r_div_dv;
    logic               r_wait_first;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_win_dd;
    logic [WIDTH-1:0]   w_win_dv;
    logic               w_win_sign;

    // First requester after the pointer, wrapping; the pointer itself is last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_dd   = req_dividend[w_win*WIDTH +: WIDTH];
    assign w_win_dv   = req_divisor[w_win*WIDTH +: WIDTH];
    assign w_win_sign = req_sign[w_win];

`ifdef DIV_ZERO_BYPASS_EN
    logic r_resp_err;
    assign resp_err = r_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_ptr        <= IDX_W'(NUM_REQ - 1);
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_q     <= '0;
            r_resp_r     <= '0;
            r_div_start  <= 1'b0;
            r_div_sign   <= 1'b0;
            r_div_dd     <= '0;
            r_div_dv     <= '0;
            r_wait_first <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            r_div_start  <= 1'b0;
            r_resp_valid <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant    <= NUM_REQ'(1) << w_win;
                        r_ptr      <= w_win;
                        r_div_sign <= w_win_sign;
                        r_div_dd   <= w_win_dd;
                        r_div_dv   <= w_win_dv;
`ifdef DIV_ZERO_BYPASS_EN
                        if (w_win_dv == '0) begin
                            r_state      <= c_st_resp;
                            r_resp_valid <= NUM_REQ'(1) << w_win;
                            r_resp_q     <= '1;
                            r_resp_r     <= w_win_dd;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= c_st_issue;
                            r_div_start <= 1'b1;
                        end
`else
                        r_state     <= c_st_issue;
                        r_div_start <= 1'b1;
`endif
                    end
                end
                c_st_issue: begin
                    r_state      <= c_st_wait;
                    r_wait_first <= 1'b1;
                end
                c_st_wait: begin
                    // A ready seen in the first wait cycle may belong to an abandoned op.
                    if (r_wait_first) begin
                        r_wait_first <= 1'b0;
                    end else if (div_ready) begin
                        r_resp_q     <= div_quotient;
                        r_resp_r     <= div_remainder;
                        r_resp_valid <= r_grant;
                        r_state      <= c_st_resp;
`ifdef DIV_ZERO_BYPASS_EN
                        r_resp_err   <= 1'b0;
`endif
                    end
                end
                c_st_resp: begin
                    r_grant <= '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign grant          = r_grant;
    assign resp_valid     = r_resp_valid;
    assign resp_quotient  = r_resp_q;
    assign resp_remainder = r_resp_r;
    assign busy           = (r_state != c_st_idle);
    assign div_start      = r_div_start;
    assign div_sign       = r_div_sign;
    assign div_dividend   = r_div_dd;
    assign div_divisor    = r_div_dv;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_arbiter
// Description : Self-checking bench for div_arbiter with an emulated divider
//               and a timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_arbiter;

    localparam int W = 13;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_sign;
    logic [N*W-1:0]   req_dividend;
    logic [N*W-1:0]   req_divisor;
    logic [N-1:0]     grant;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_quotient;
    logic [W-1:0]     resp_remainder;
    logic             resp_err;
    logic             busy;
    logic             div_start;
    logic             div_sign;
    logic [W-1:0]     div_dividend;
    logic [W-1:0]     div_divisor;
    logic [W-1:0]     div_quotient;
    logic [W-1:0]     div_remainder;
    logic             div_ready;

    div_arbiter #(.WIDTH(W), .NUM_REQ(N), .IDX_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_sign       (req_sign),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .grant          (grant),
        .resp_valid     (resp_valid),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_err       (resp_err),
        .busy           (busy),
        .div_start      (div_start),
        .div_sign       (div_sign),
        .div_dividend   (div_dividend),
        .div_divisor    (div_divisor),
        .div_quotient   (div_quotient),
        .div_remainder  (div_remainder),
        .div_ready      (div_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle.
    logic [N-1:0] e_grant, e_resp_valid;
    logic [W-1:0] e_q, e_r, e_dd, e_dv;
    logic         e_busy, e_start, e_sign;

    // Model: owner, cycles since grant (t), ready offset L, RR pointer.
    bit           m_busy;
    int           m_t, m_L, m_owner, m_ptr;
    bit           pend [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_t = 0; m_L = 0; m_owner = 0; m_ptr = N - 1;
        e_grant = '0; e_resp_valid = '0; e_q = '0; e_r = '0;
        e_dd = '0; e_dv = '0; e_busy = 1'b0; e_start = 1'b0; e_sign = 1'b0;
    endtask

    // Derive next-cycle expectations from the inputs applied this cycle.
    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_start      = 1'b0;
        e_resp_valid = '0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + 1 + k) % N;
                if (!m_busy && req_valid[idx]) begin
                    m_busy  = 1'b1;
                    m_owner = idx;
                    m_ptr   = idx;
                    m_t     = 0;
                    m_L     = $urandom_range(2, 6);
                    e_grant = N'(1) << idx;
                    e_busy  = 1'b1;
                    e_start = 1'b1;
                    e_sign  = req_sign[idx];
                    e_dd    = req_dividend[idx*W +: W];
                    e_dv    = req_divisor[idx*W +: W];
                end
            end
        end else begin
            if (m_t == m_L) begin
                e_resp_valid = e_grant;
                e_q          = div_quotient;
                e_r          = div_remainder;
            end else if (m_t == m_L + 1) begin
                m_busy  = 1'b0;
                e_grant = '0;
                e_busy  = 1'b0;
            end
            m_t++;
        end
    endtask

    // Emulated divider: true result at t==L, spurious pulses outside live WAIT.
    task automatic drive_divider();
        logic signed [W-1:0] sa, sb;
        div_ready     = 1'b0;
        div_quotient  = W'($urandom);
        div_remainder = W'($urandom);
        if (m_busy && m_t == m_L) begin
            div_ready = 1'b1;
            sa = e_dd;
            sb = e_dv;
            if (e_dv == '0) begin
                div_quotient  = '1;
                div_remainder = e_dd;
            end else if (e_sign) begin
                div_quotient  = sa / sb;
                div_remainder = sa % sb;
            end else begin
                div_quotient  = e_dd / e_dv;
                div_remainder = e_dd % e_dv;
            end
        end else if (m_busy && m_t == 1) begin
            div_ready = 1'b1;
        end else if ((!m_busy || m_t == 0) && ($urandom % 4 == 0)) begin
            div_ready = 1'b1;
        end
    endtask

    task automatic compare();
        check("grant",          32'(grant),          32'(e_grant));
        check("resp_valid",     32'(resp_valid),     32'(e_resp_valid));
        check("busy",           32'(busy),           32'(e_busy));
        check("div_start",      32'(div_start),      32'(e_start));
        check("div_sign",       32'(div_sign),       32'(e_sign));
        check("div_dividend",   32'(div_dividend),   32'(e_dd));
        check("div_divisor",    32'(div_divisor),    32'(e_dv));
        check("resp_quotient",  32'(resp_quotient),  32'(e_q));
        check("resp_remainder", 32'(resp_remainder), 32'(e_r));
        check("resp_err",       32'(resp_err),       32'(0));
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        compare();
        drive_divider();
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (e_resp_valid == '0 && n < 40);
        if (e_resp_valid == '0) begin
            errors++;
            $display("FAIL %s timeout: actual=no response expected=response", name);
        end
    endtask

    task automatic set_op(input int i, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        req_sign[i]           = s;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_sign = '0;
        req_dividend = '0; req_divisor = '0;
        div_ready = 1'b0; div_quotient = '0; div_remainder = '0;
        model_reset();
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        rst_n = 1'b1;
        tick();

        // Single unsigned request.
        set_op(0, 1'b0, 13'd100, 13'd7);
        req_valid = 4'b0001;
        wait_resp("unsigned");
        check("unsigned_rv", 32'(resp_valid), 32'h1);
        check("unsigned_q",  32'(resp_quotient), 32'd14);
        check("unsigned_r",  32'(resp_remainder), 32'd2);
        req_valid = '0;
        tick();
        tick();
        check("unsigned_idle", 32'(busy), 32'(0));

        // Signed request on requester 2.
        set_op(2, 1'b1, 13'h1F9C, 13'd7);
        req_valid = 4'b0100;
        wait_resp("signed");
        check("signed_rv", 32'(resp_valid), 32'h4);
        check("signed_q",  32'(resp_quotient), 32'h1FF2);
        check("signed_r",  32'(resp_remainder), 32'h1FFE);
        req_valid = '0;
        tick();

        // Fairness from a freshly reset pointer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 1'b0, W'(200 + 37 * i), W'(3 + i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_resp("fair");
            check("fair_order", 32'(resp_valid), 32'(1 << (k % N)));
        end
        req_valid = '0;
        tick();

        // Requester 1 raised while 3 is busy is served next.
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1010;
        wait_resp("prio3");
        check("prio_first", 32'(resp_valid), 32'h8);
        req_valid = 4'b0010;
        wait_resp("prio1");
        check("prio_wrap", 32'(resp_valid), 32'h2);
        req_valid = '0;
        tick();

        // Reset during WAIT abandons the op; the retry completes.
        req_valid = 4'b0010;
        begin
            int n = 0;
            while (!(m_busy && m_t == 2) && n < 20) begin
                tick();
                n++;
            end
            if (!(m_busy && m_t == 2)) begin
                errors++;
                $display("FAIL midwait_reach: actual=not reached expected=WAIT");
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy",  32'(busy), 32'(0));
        check("midrst_grant", 32'(grant), 32'(0));
        check("midrst_start", 32'(div_start), 32'(0));
        wait_resp("midrst_retry");
        check("midrst_retry_rv", 32'(resp_valid), 32'h2);
        req_valid = '0;
        tick();

        // Randomized traffic with occasional resets and drops.
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (e_resp_valid[i]) pend[i] = 1'b0;
                else if (!pend[i] && ($urandom % 6 == 0)) pend[i] = 1'b1;
                else if (pend[i] && m_busy && m_owner == i && ($urandom % 32 == 0)) pend[i] = 1'b0;
                req_valid[i] = pend[i];
                req_sign[i]  = 1'($urandom);
                req_dividend[i*W +: W] = W'($urandom);
                req_divisor[i*W +: W]  = ($urandom % 8 == 0) ? '0 : W'($urandom);
            end
            rst_n = ($urandom % 300 != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
